// File: rtl/psram_define.sv
// Shared opcode constants and FSM state encoding for the octal-DDR PSRAM responder.
package psram_define;

    localparam logic [7:0] PSRAM_CMD_RD  = 8'h00;
    localparam logic [7:0] PSRAM_CMD_WR  = 8'h80;
    localparam logic [7:0] PSRAM_CMD_MRR = 8'h40;
    localparam logic [7:0] PSRAM_CMD_MRW = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LAT,
        ST_RDATA,
        ST_WDATA,
        ST_DRAIN
    } psram_resp_state_e;

    function automatic logic psram_op_known(input logic [7:0] op);
        return (op == PSRAM_CMD_RD) || (op == PSRAM_CMD_WR) ||
               (op == PSRAM_CMD_MRR) || (op == PSRAM_CMD_MRW);
    endfunction

    function automatic logic psram_op_is_read(input logic [7:0] op);
        return (op == PSRAM_CMD_RD) || (op == PSRAM_CMD_MRR);
    endfunction

endpackage

// File: rtl/psram_edge_sync.sv
// Two-flop synchronizer for the PSRAM pad inputs plus SCK edge detection.
// The edge pulse is registered together with the data so both stay aligned.
module psram_edge_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       ce_i,
    input  logic [7:0] io_i,
    input  logic       dqs_i,
    output logic       ce_s,
    output logic [7:0] io_s,
    output logic       dqs_s,
    output logic       edge_o
);
    // Packed as {ce, sck, dqs, io}
    logic [10:0] sync1_q, sync1_d;
    logic [10:0] sync2_q, sync2_d;
    logic        sck_prev_q, sck_prev_d;
    logic        edge_q, edge_d;
    logic [9:0]  out_q, out_d;

    always_comb begin
        sync1_d    = {ce_i, sck_i, dqs_i, io_i};
        sync2_d    = sync1_q;
        sck_prev_d = sync2_q[9];
        edge_d     = sync2_q[9] ^ sck_prev_q;
        out_d      = {sync2_q[10], sync2_q[8:0]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sck_prev_q <= 1'b0;
            edge_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sck_prev_q <= sck_prev_d;
            edge_q     <= edge_d;
            out_q      <= out_d;
        end
    end

    assign ce_s   = out_q[9];
    assign dqs_s  = out_q[8];
    assign io_s   = out_q[7:0];
    assign edge_o = edge_q;

endmodule

// File: rtl/psram_resp.sv
// Octal-DDR PSRAM device model: decodes command/address frames from the pads,
// serves a byte array and an 8-entry mode-register file, returns data with DQS.
module psram_resp #(
    parameter int         ADDR_WIDTH = 12,
    parameter int         LATENCY    = 5,
    parameter logic [7:0] VENDOR_ID  = 8'h0D
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_i,
    output logic [7:0] psram_io_o,
    output logic [7:0] psram_io_en_o,
    input  logic       psram_dqs_i,
    output logic       psram_dqs_o,
    output logic       psram_dqs_en_o,
    output logic       busy_o
);
    import psram_define::*;

    localparam logic [7:0]            LAT_LAST = 8'(2 * LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic       ce_s;
    logic [7:0] io_s;
    logic       dqs_s;
    logic       edge_s;

    psram_edge_sync u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sck_i  (psram_sck_i),
        .ce_i   (psram_ce_i),
        .io_i   (psram_io_i),
        .dqs_i  (psram_dqs_i),
        .ce_s   (ce_s),
        .io_s   (io_s),
        .dqs_s  (dqs_s),
        .edge_o (edge_s)
    );

    psram_resp_state_e     state_q, state_d;
    logic                  ce_prev_q, ce_prev_d;
    logic [7:0]            ecnt_q, ecnt_d;
    logic [7:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            mr_q [8];
    logic [7:0]            mr_d [8];
    logic                  mr_done_q, mr_done_d;
    logic [7:0]            io_q, io_d;
    logic [7:0]            io_en_q, io_en_d;
    logic                  dqs_q, dqs_d;
    logic                  dqs_en_q, dqs_en_d;
    logic                  mem_we;
    logic [7:0]            rd_byte;
    logic [7:0]            mem [2**ADDR_WIDTH];

    assign rd_byte = (op_q == PSRAM_CMD_MRR) ? mr_q[addr_q[2:0]] : mem[addr_q];

    // Next-state logic; a deasserted CE# overrides everything.
    always_comb begin
        state_d = state_q;
        if (ce_s) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (ce_prev_q) state_d = ST_CMD;
                ST_CMD: begin
                    if (edge_s && ecnt_q == 8'd1) begin
                        if (io_s != op_q || !psram_op_known(io_s)) state_d = ST_DRAIN;
                        else                                       state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (edge_s && ecnt_q == 8'd5)
                        state_d = (op_q == PSRAM_CMD_MRW) ? ST_WDATA : ST_LAT;
                end
                ST_LAT: begin
                    if (edge_s && ecnt_q == LAT_LAST)
                        state_d = psram_op_is_read(op_q) ? ST_RDATA : ST_WDATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ce_prev_d = ce_s;
        ecnt_d    = ecnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        mr_d      = mr_q;
        mr_done_d = mr_done_q;
        mem_we    = 1'b0;
        if (state_q == ST_IDLE) begin
            ecnt_d    = 8'd0;
            mr_done_d = 1'b0;
        end else if (edge_s && !ce_s) begin
            unique case (state_q)
                ST_CMD: begin
                    if (ecnt_q == 8'd0) op_d = io_s;
                    ecnt_d = ecnt_q + 8'd1;
                end
                ST_ADDR: begin
                    addr_d = ADDR_WIDTH'({addr_q, io_s});
                    ecnt_d = (ecnt_q == 8'd5) ? 8'd0 : ecnt_q + 8'd1;
                end
                ST_LAT: ecnt_d = ecnt_q + 8'd1;
                ST_RDATA: begin
                    if (op_q == PSRAM_CMD_RD) addr_d = addr_q + ADDR_ONE;
                end
                ST_WDATA: begin
                    if (op_q == PSRAM_CMD_MRW) begin
                        if (!mr_done_q) begin
                            mr_d[addr_q[2:0]] = io_s;
                            mr_done_d         = 1'b1;
                        end
                    end else begin
                        // Masked bytes still advance the address
                        mem_we = !dqs_s;
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                default: ecnt_d = ecnt_q;
            endcase
        end
    end

    // Pad outputs; DQS is held low through read latency and toggles once per byte.
    always_comb begin
        io_d     = 8'h00;
        io_en_d  = 8'h00;
        dqs_d    = 1'b0;
        dqs_en_d = 1'b0;
        unique case (state_d)
            ST_LAT: dqs_en_d = psram_op_is_read(op_q);
            ST_RDATA: begin
                io_en_d  = 8'hFF;
                dqs_en_d = 1'b1;
                if (state_q == ST_RDATA && edge_s) begin
                    io_d  = rd_byte;
                    dqs_d = ~dqs_q;
                end else begin
                    io_d  = io_q;
                    dqs_d = dqs_q;
                end
            end
            default: io_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ce_prev_q <= 1'b0;
            ecnt_q    <= 8'd0;
            op_q      <= 8'd0;
            addr_q    <= '0;
            mr_done_q <= 1'b0;
            io_q      <= 8'h00;
            io_en_q   <= 8'h00;
            dqs_q     <= 1'b0;
            dqs_en_q  <= 1'b0;
            for (int i = 0; i < 8; i++) mr_q[i] <= (i == 1) ? VENDOR_ID : 8'h00;
        end else begin
            state_q   <= state_d;
            ce_prev_q <= ce_prev_d;
            ecnt_q    <= ecnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            mr_done_q <= mr_done_d;
            io_q      <= io_d;
            io_en_q   <= io_en_d;
            dqs_q     <= dqs_d;
            dqs_en_q  <= dqs_en_d;
            mr_q      <= mr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) mem[addr_q] <= io_s;
    end

    assign psram_io_o     = io_q;
    assign psram_io_en_o  = io_en_q;
    assign psram_dqs_o    = dqs_q;
    assign psram_dqs_en_o = dqs_en_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_psram_resp.sv
// Directed bench for psram_resp: drives pad-level frames and checks returned bytes/strobes.
module tb_psram_resp;
    localparam int LAT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] io = 8'h00;
    logic       dqs = 1'b0;
    logic [7:0] psram_io_o;
    logic [7:0] psram_io_en_o;
    logic       psram_dqs_o;
    logic       psram_dqs_en_o;
    logic       busy_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    psram_resp #(.ADDR_WIDTH(12), .LATENCY(LAT), .VENDOR_ID(8'h0D)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce),
        .psram_io_i     (io),
        .psram_io_o     (psram_io_o),
        .psram_io_en_o  (psram_io_en_o),
        .psram_dqs_i    (dqs),
        .psram_dqs_o    (psram_dqs_o),
        .psram_dqs_en_o (psram_dqs_en_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // SCK edge with data set up 20 ns before and held 20 ns after
    task automatic edge_tx(input logic [7:0] b, input logic dm);
        io = b; dqs = dm; #20; sck = ~sck; #20;
    endtask

    task automatic edge_rd(output logic [7:0] b, output logic d);
        #20; sck = ~sck; #40; b = psram_io_o; d = psram_dqs_o;
    endtask

    task automatic frame_start(input logic [7:0] op, input logic [31:0] a);
        ce = 1'b0; #40;
        edge_tx(op, 1'b0);
        edge_tx(op, 1'b0);
        for (int i = 3; i >= 0; i--) edge_tx(a[i*8 +: 8], 1'b0);
    endtask

    task automatic frame_end();
        #40; ce = 1'b1; io = 8'h00; dqs = 1'b0; #80;
    endtask

    task automatic write_frame(input logic [31:0] a, input logic [31:0] d, input logic [3:0] dm, input int n);
        frame_start(8'h80, a);
        repeat (2 * LAT) edge_tx(8'h00, 1'b0);
        for (int i = 0; i < n; i++) edge_tx(d[31-8*i -: 8], dm[3-i]);
        frame_end();
    endtask

    task automatic read_frame(input logic [7:0] op, input logic [31:0] a, input int n,
                              output logic [31:0] data, output logic [3:0] dq);
        logic [7:0] b;
        logic       d;
        data = '0; dq = '0;
        frame_start(op, a);
        repeat (2 * LAT) edge_tx(8'h00, 1'b0);
        for (int i = 0; i < n; i++) begin
            edge_rd(b, d);
            data[31-8*i -: 8] = b;
            dq[3-i] = d;
        end
        frame_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        vec_cnt++; if (psram_io_o !== 8'h00) begin err_cnt++; $display("FAIL rst_io got=%h exp=00", psram_io_o); end
        vec_cnt++; if (psram_io_en_o !== 8'h00) begin err_cnt++; $display("FAIL rst_io_en got=%h exp=00", psram_io_en_o); end
        vec_cnt++; if (psram_dqs_o !== 1'b0) begin err_cnt++; $display("FAIL rst_dqs got=%b exp=0", psram_dqs_o); end
        vec_cnt++; if (psram_dqs_en_o !== 1'b0) begin err_cnt++; $display("FAIL rst_dqs_en got=%b exp=0", psram_dqs_en_o); end
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_mr_read();
        logic [7:0] b;
        logic       d;
        frame_start(8'h40, 32'h0000_0001);
        edge_tx(8'h00, 1'b0);
        #20;
        vec_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL mrr_busy got=%b exp=1", busy_o); end
        vec_cnt++; if (psram_dqs_en_o !== 1'b1 || psram_dqs_o !== 1'b0)
            begin err_cnt++; $display("FAIL mrr_lat_dqs got en=%b dqs=%b exp en=1 dqs=0", psram_dqs_en_o, psram_dqs_o); end
        vec_cnt++; if (psram_io_en_o !== 8'h00) begin err_cnt++; $display("FAIL mrr_lat_io_en got=%h exp=00", psram_io_en_o); end
        repeat (2 * LAT - 1) edge_tx(8'h00, 1'b0);
        edge_rd(b, d);
        vec_cnt++; if (b !== 8'h0D || d !== 1'b1) begin err_cnt++; $display("FAIL mrr_byte0 got=%h/%b exp=0d/1", b, d); end
        vec_cnt++; if (psram_io_en_o !== 8'hFF) begin err_cnt++; $display("FAIL mrr_io_en got=%h exp=ff", psram_io_en_o); end
        edge_rd(b, d);
        vec_cnt++; if (b !== 8'h0D || d !== 1'b0) begin err_cnt++; $display("FAIL mrr_byte1 got=%h/%b exp=0d/0", b, d); end
        frame_end();
        vec_cnt++; if (psram_io_en_o !== 8'h00 || psram_dqs_en_o !== 1'b0 || busy_o !== 1'b0)
            begin err_cnt++; $display("FAIL mrr_end got io_en=%h dqs_en=%b busy=%b exp 00/0/0", psram_io_en_o, psram_dqs_en_o, busy_o); end
    endtask

    task automatic test_masked_write();
        logic [31:0] data;
        logic [3:0]  dq;
        write_frame(32'h10, 32'hA55A_0000, 4'b0000, 2);
        write_frame(32'h10, 32'h1122_3344, 4'b0100, 4);
        read_frame(8'h00, 32'h10, 4, data, dq);
        vec_cnt++; if (data !== 32'h115A_3344) begin err_cnt++; $display("FAIL masked_data got=%h exp=115a3344", data); end
        vec_cnt++; if (dq !== 4'b1010) begin err_cnt++; $display("FAIL masked_dqs got=%b exp=1010", dq); end
    endtask

    task automatic test_wrap();
        logic [31:0] data;
        logic [3:0]  dq;
        write_frame(32'hFFF, 32'hAABB_0000, 4'b0000, 2);
        read_frame(8'h00, 32'hFFF, 2, data, dq);
        vec_cnt++; if (data[31:16] !== 16'hAABB) begin err_cnt++; $display("FAIL wrap_fff got=%h exp=aabb", data[31:16]); end
        read_frame(8'h00, 32'h000, 1, data, dq);
        vec_cnt++; if (data[31:24] !== 8'hBB) begin err_cnt++; $display("FAIL wrap_000 got=%h exp=bb", data[31:24]); end
    endtask

    task automatic test_bad_opcode();
        logic [31:0] data;
        logic [3:0]  dq;
        logic        seen_en = 1'b0;
        ce = 1'b0; #40;
        edge_tx(8'h00, 1'b0);
        edge_tx(8'h80, 1'b0);
        for (int i = 0; i < 8; i++) begin
            edge_tx((i == 3) ? 8'h10 : ((i < 3) ? 8'h00 : 8'h77), 1'b0);
            if (psram_io_en_o !== 8'h00 || psram_dqs_en_o !== 1'b0) seen_en = 1'b1;
        end
        #20;
        vec_cnt++; if (seen_en !== 1'b0) begin err_cnt++; $display("FAIL bad_op_enable got=%b exp=0", seen_en); end
        vec_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL bad_op_busy got=%b exp=1", busy_o); end
        frame_end();
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL bad_op_busy_end got=%b exp=0", busy_o); end
        read_frame(8'h00, 32'h10, 2, data, dq);
        vec_cnt++; if (data[31:16] !== 16'h115A) begin err_cnt++; $display("FAIL bad_op_mem got=%h exp=115a", data[31:16]); end
    endtask

    task automatic test_abort_write();
        logic [31:0] data;
        logic [3:0]  dq;
        write_frame(32'h20, 32'h1020_3040, 4'b0000, 4);
        frame_start(8'h80, 32'h20);
        repeat (2 * LAT) edge_tx(8'h00, 1'b0);
        edge_tx(8'hC1, 1'b0);
        edge_tx(8'hC2, 1'b0);
        #40; ce = 1'b1; #40;
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL abort_idle got busy=%b exp=0", busy_o); end
        #40;
        read_frame(8'h00, 32'h20, 4, data, dq);
        vec_cnt++; if (data !== 32'hC1C2_3040) begin err_cnt++; $display("FAIL abort_data got=%h exp=c1c23040", data); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] data;
        logic [3:0]  dq;
        logic [7:0]  b;
        logic        d;
        frame_start(8'hC0, 32'h1);
        edge_tx(8'h99, 1'b0);
        edge_tx(8'h55, 1'b0);
        frame_end();
        read_frame(8'h40, 32'h1, 1, data, dq);
        vec_cnt++; if (data[31:24] !== 8'h99) begin err_cnt++; $display("FAIL mrw_mr1 got=%h exp=99", data[31:24]); end
        frame_start(8'h00, 32'h20);
        repeat (2 * LAT) edge_tx(8'h00, 1'b0);
        edge_rd(b, d);
        vec_cnt++; if (b !== 8'hC1 || psram_io_en_o !== 8'hFF)
            begin err_cnt++; $display("FAIL pre_rst_read got=%h/%h exp=c1/ff", b, psram_io_en_o); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        vec_cnt++; if (psram_io_o !== 8'h00 || psram_io_en_o !== 8'h00 || psram_dqs_o !== 1'b0 ||
                       psram_dqs_en_o !== 1'b0 || busy_o !== 1'b0)
            begin err_cnt++; $display("FAIL mid_rst_outputs got io=%h en=%h dqs=%b dqs_en=%b busy=%b exp all 0",
                                      psram_io_o, psram_io_en_o, psram_dqs_o, psram_dqs_en_o, busy_o); end
        rst = 1'b0;
        frame_end();
        read_frame(8'h40, 32'h1, 1, data, dq);
        vec_cnt++; if (data[31:24] !== 8'h0D || dq[3] !== 1'b1)
            begin err_cnt++; $display("FAIL post_rst_mr1 got=%h/%b exp=0d/1", data[31:24], dq[3]); end
    endtask

    initial begin
        test_reset();
        test_mr_read();
        test_masked_write();
        test_wrap();
        test_bad_opcode();
        test_abort_write();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
